// File: rtl/pdp11_bus_pkg.sv
// rtl/pdp11_bus_pkg.sv - shared state, op encoding and memory-map constants for the CPU RAM bus
package pdp11_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } bus_state_e;

    // Unibus-style cycle types; byte reads are plain DATI with the byte flag set
    typedef enum logic [1:0] {
        OP_DATI  = 2'd0,
        OP_DATO  = 2'd1,
        OP_DATOB = 2'd2
    } bus_op_e;

    localparam logic [15:0] MEM_TOP_DEFAULT = 16'o040000;
    localparam int unsigned WAIT_W          = 3;

    function automatic bus_op_e op_encode(input logic wr, input logic byte_acc);
        if (!wr)
            return OP_DATI;
        return byte_acc ? OP_DATOB : OP_DATO;
    endfunction

endpackage

// File: rtl/ram_addr_check.sv
// rtl/ram_addr_check.sv - combinational odd-address and non-existent-memory decode
module ram_addr_check
    import pdp11_bus_pkg::*;
#(
    parameter logic [15:0] MEM_TOP = MEM_TOP_DEFAULT
) (
    input  logic [15:0] addr_i,
    input  logic        byte_i,
    output logic        odd_o,
    output logic        nxm_o
);

    // Byte accesses may use either lane; only word accesses must be even
    assign odd_o = addr_i[0] & ~byte_i;
    assign nxm_o = (addr_i >= MEM_TOP);

endmodule

// File: rtl/ram_bus_ctl.sv
// rtl/ram_bus_ctl.sv - CPU-side request/ack controller driving the byte-capable RAM strobes
module ram_bus_ctl
    import pdp11_bus_pkg::*;
#(
    parameter logic [15:0] MEM_TOP   = MEM_TOP_DEFAULT,
    parameter int unsigned READ_WAIT = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        bus_req,
    input  logic        bus_wr,
    input  logic        bus_byte,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wdata,
    output logic        bus_ack,
    output logic        bus_err,
    output logic [15:0] bus_rdata,
    output logic [15:0] err_addr,
    output logic        err_odd,
    output logic [15:0] ram_a,
    output logic [15:0] ram_di,
    input  logic [15:0] ram_do,
    output logic        ram_ce_n,
    output logic        ram_we_n,
    output logic        ram_byte_op
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

    bus_state_e        state_q, state_d;
    bus_op_e           op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [15:0]       ram_a_q, ram_a_d;
    logic [15:0]       ram_di_q, ram_di_d;
    logic              byte_q, byte_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [15:0]       err_addr_q, err_addr_d;
    logic              err_odd_q, err_odd_d;
    logic              addr_odd, addr_nxm;

    // Decode runs on the registered request so the check sees stable fields
    ram_addr_check #(.MEM_TOP(MEM_TOP)) u_check (
        .addr_i (ram_a_q),
        .byte_i (byte_q),
        .odd_o  (addr_odd),
        .nxm_o  (addr_nxm)
    );

    // Next-state and strobe decode; strobes only ever leave inactive in WRITE/READ
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_d     = wait_q;
        ram_a_d    = ram_a_q;
        ram_di_d   = ram_di_q;
        byte_d     = byte_q;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;
        err_odd_d  = err_odd_q;
        bus_ack    = 1'b0;
        bus_err    = 1'b0;
        ram_ce_n   = 1'b1;
        ram_we_n   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (bus_req) begin
                    ram_a_d  = bus_addr;
                    // Byte data goes to both lanes; the RAM picks the lane from ram_a[0]
                    ram_di_d = bus_byte ? {bus_wdata[7:0], bus_wdata[7:0]} : bus_wdata;
                    byte_d   = bus_byte;
                    op_d     = op_encode(bus_wr, bus_byte);
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                wait_d = '0;
                if (addr_odd) begin
                    err_odd_d = 1'b1;
                    state_d   = ST_FAULT;
                end else if (addr_nxm) begin
                    err_odd_d = 1'b0;
                    state_d   = ST_FAULT;
                end else if (op_q == OP_DATI) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_ce_n = 1'b0;
                ram_we_n = 1'b0;
                state_d  = ST_DONE;
            end
            ST_READ: begin
                ram_ce_n = 1'b0;
                if (wait_q == WAIT_LAST) begin
                    rdata_d = ram_do;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DONE: begin
                bus_ack = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                bus_err    = 1'b1;
                err_addr_d = ram_a_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers; reset abandons any transfer in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_DATI;
            wait_q     <= '0;
            ram_a_q    <= '0;
            ram_di_q   <= '0;
            byte_q     <= 1'b0;
            rdata_q    <= '0;
            err_addr_q <= '0;
            err_odd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_q     <= wait_d;
            ram_a_q    <= ram_a_d;
            ram_di_q   <= ram_di_d;
            byte_q     <= byte_d;
            rdata_q    <= rdata_d;
            err_addr_q <= err_addr_d;
            err_odd_q  <= err_odd_d;
        end
    end

    assign ram_a       = ram_a_q;
    assign ram_di      = ram_di_q;
    assign ram_byte_op = byte_q;
    assign bus_rdata   = rdata_q;
    assign err_addr    = err_addr_q;
    assign err_odd     = err_odd_q;

endmodule

// File: tb/tb_ram_bus_ctl.sv
// tb/tb_ram_bus_ctl.sv - scoreboard bench for ram_bus_ctl with a behavioural byte-lane RAM
module tb_ram_bus_ctl;

    localparam int RW = 1;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        bus_req, bus_wr, bus_byte;
    logic [15:0] bus_addr, bus_wdata;
    logic        bus_ack, bus_err, err_odd;
    logic [15:0] bus_rdata, err_addr, ram_a, ram_di, ram_do;
    logic        ram_ce_n, ram_we_n, ram_byte_op;

    logic        rst3, req3;
    logic [15:0] addr3;
    logic        ack3, err3, eodd3, ce3, we3, bop3;
    logic [15:0] rdata3, eaddr3, a3, di3, ram_do3;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int we_cnt = 0;
    int ce_cnt = 0;
    int viol = 0;
    int ack3_cnt = 0;

    logic [15:0] mem [0:8191];
    logic [15:0] rd_word;

    typedef struct {
        bit          is_err;
        bit          chk_rd;
        logic [15:0] rd;
        bit          odd;
        logic [15:0] eaddr;
        int          lat;
        int          issue;
        int          we0;
        int          ce0;
        int          exp_we;
        int          exp_ce;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    always #5 CLK = ~CLK;

    ram_bus_ctl #(.READ_WAIT(RW)) u_dut (
        .CLK(CLK), .RESET(RESET), .bus_req(bus_req), .bus_wr(bus_wr), .bus_byte(bus_byte),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .bus_rdata(bus_rdata), .err_addr(err_addr), .err_odd(err_odd), .ram_a(ram_a),
        .ram_di(ram_di), .ram_do(ram_do), .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n),
        .ram_byte_op(ram_byte_op)
    );

    assign ram_do3 = 16'o012345;

    ram_bus_ctl #(.READ_WAIT(3)) u_dut3 (
        .CLK(CLK), .RESET(rst3), .bus_req(req3), .bus_wr(1'b0), .bus_byte(1'b0),
        .bus_addr(addr3), .bus_wdata(16'h0000), .bus_ack(ack3), .bus_err(err3),
        .bus_rdata(rdata3), .err_addr(eaddr3), .err_odd(eodd3), .ram_a(a3),
        .ram_di(di3), .ram_do(ram_do3), .ram_ce_n(ce3), .ram_we_n(we3),
        .ram_byte_op(bop3)
    );

    always_comb begin
        rd_word = mem[ram_a[13:1]];
        if (ram_byte_op)
            ram_do = ram_a[0] ? {8'h00, rd_word[15:8]} : {8'h00, rd_word[7:0]};
        else
            ram_do = rd_word;
    end

    always @(posedge CLK) begin
        cyc++;
        if (!ram_ce_n) ce_cnt++;
        if (!ram_ce_n && !ram_we_n) begin
            we_cnt++;
            if (!ram_byte_op)
                mem[ram_a[13:1]] <= ram_di;
            else if (ram_a[0])
                mem[ram_a[13:1]][15:8] <= ram_di[15:8];
            else
                mem[ram_a[13:1]][7:0] <= ram_di[7:0];
        end
    end

    always @(negedge CLK) begin
        if (!ram_we_n && (ram_ce_n || u_dut.state_q != 3'd2)) viol++;
        if (!we3) viol++;
        if (ack3) ack3_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ack/err pulse
    always @(negedge CLK) begin
        if (!RESET && (bus_ack || bus_err)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_response: ack=%0b err=%0b", bus_ack, bus_err);
            end else begin
                me = sb.pop_front();
                chk("resp_kind_err", 32'(bus_err), 32'(me.is_err));
                chk("latency", 32'(cyc - me.issue), 32'(me.lat));
                chk("we_pulses", 32'(we_cnt - me.we0), 32'(me.exp_we));
                chk("ce_cycles", 32'(ce_cnt - me.ce0), 32'(me.exp_ce));
                if (!me.is_err && me.chk_rd)
                    chk("rdata", 32'(bus_rdata), 32'(me.rd));
                if (me.is_err) begin
                    @(posedge CLK);
                    #1;
                    chk("err_odd", 32'(err_odd), 32'(me.odd));
                    chk("err_addr", 32'(err_addr), 32'(me.eaddr));
                end
            end
        end
    end

    task automatic do_req(input logic wr, input logic bt, input logic [15:0] addr,
                          input logic [15:0] wd, input bit is_err, input bit odd,
                          input logic [15:0] rd, input bit chk_rd);
        exp_t e;
        bit   seen;
        e.is_err = is_err;
        e.chk_rd = chk_rd;
        e.rd     = rd;
        e.odd    = odd;
        e.eaddr  = addr;
        e.lat    = is_err ? 2 : (wr ? 3 : 2 + RW);
        e.exp_we = (!is_err && wr) ? 1 : 0;
        e.exp_ce = is_err ? 0 : (wr ? 1 : RW);
        e.issue  = cyc;
        e.we0    = we_cnt;
        e.ce0    = ce_cnt;
        sb.push_back(e);
        bus_req   = 1'b1;
        bus_wr    = wr;
        bus_byte  = bt;
        bus_addr  = addr;
        bus_wdata = wd;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus_ack || bus_err) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: addr=%0o got no response expected ack/err", addr);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(posedge CLK);
        #1;
        bus_req = 1'b0;
    endtask

    task automatic do_read3(input logic [15:0] addr, input logic [15:0] exp_rd);
        int  c0;
        bit  seen;
        c0    = cyc;
        req3  = 1'b1;
        addr3 = addr;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (ack3) begin
                seen = 1'b1;
                chk("rw3_latency", 32'(cyc - c0), 32'd5);
                chk("rw3_rdata", 32'(rdata3), 32'(exp_rd));
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL rw3_timeout: got no ack expected ack");
        end
        @(posedge CLK);
        #1;
        req3 = 1'b0;
    endtask

    task automatic chk_reset3(input string tag);
        chk({tag, "_ack"}, 32'(ack3), 32'd0);
        chk({tag, "_err"}, 32'(err3), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata3), 32'd0);
        chk({tag, "_ram_a"}, 32'(a3), 32'd0);
        chk({tag, "_ram_di"}, 32'(di3), 32'd0);
        chk({tag, "_ce_n"}, 32'(ce3), 32'd1);
        chk({tag, "_byte_op"}, 32'(bop3), 32'd0);
        chk({tag, "_err_addr"}, 32'(eaddr3), 32'd0);
        chk({tag, "_err_odd"}, 32'(eodd3), 32'd0);
    endtask

    initial begin
        int ack_before;
        foreach (mem[i]) mem[i] = 16'h0000;
        RESET = 1'b1; rst3 = 1'b1;
        bus_req = 1'b0; bus_wr = 1'b0; bus_byte = 1'b0; bus_addr = '0; bus_wdata = '0;
        req3 = 1'b0; addr3 = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ack", 32'(bus_ack), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_rdata", 32'(bus_rdata), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        chk("rst_err_odd", 32'(err_odd), 32'd0);
        chk("rst_ce_n", 32'(ram_ce_n), 32'd1);
        chk("rst_we_n", 32'(ram_we_n), 32'd1);
        chk("rst_byte_op", 32'(ram_byte_op), 32'd0);
        chk("rst_ram_a", 32'(ram_a), 32'd0);
        chk("rst_ram_di", 32'(ram_di), 32'd0);
        chk_reset3("rst3");
        RESET = 1'b0; rst3 = 1'b0;

        //       wr    byte  addr        wdata       err odd  rdata       chk
        do_req(1'b1, 1'b0, 16'o000500, 16'o012706, 0,  0,  16'o000000, 0);
        do_req(1'b0, 1'b0, 16'o000500, 16'o000000, 0,  0,  16'o012706, 1);
        do_req(1'b0, 1'b1, 16'o000501, 16'o000000, 0,  0,  16'o000025, 1);
        do_req(1'b0, 1'b1, 16'o000500, 16'o000000, 0,  0,  16'o000306, 1);
        do_req(1'b1, 1'b0, 16'o000500, 16'o000000, 0,  0,  16'o000000, 0);
        do_req(1'b1, 1'b1, 16'o000501, 16'hA5FF,   0,  0,  16'o000000, 0);
        do_req(1'b0, 1'b0, 16'o000500, 16'o000000, 0,  0,  16'o177400, 1);
        do_req(1'b0, 1'b0, 16'o000503, 16'o000000, 1,  1,  16'o000000, 0);
        do_req(1'b1, 1'b0, 16'o040000, 16'o111111, 1,  0,  16'o000000, 0);
        do_req(1'b0, 1'b0, 16'o000000, 16'o000000, 0,  0,  16'o000000, 1);
        do_req(1'b1, 1'b0, 16'o037776, 16'o054321, 0,  0,  16'o000000, 0);
        do_req(1'b0, 1'b0, 16'o037776, 16'o000000, 0,  0,  16'o054321, 1);
        do_req(1'b0, 1'b0, 16'o040001, 16'o000000, 1,  1,  16'o000000, 0);
        do_req(1'b0, 1'b1, 16'o040001, 16'o000000, 1,  0,  16'o000000, 0);
        do_req(1'b1, 1'b1, 16'o000500, 16'o000252, 0,  0,  16'o000000, 0);
        do_req(1'b0, 1'b0, 16'o000500, 16'o000000, 0,  0,  16'o177652, 1);

        do_read3(16'o001000, 16'o012345);
        req3  = 1'b1;
        addr3 = 16'o002000;
        repeat (3) @(posedge CLK);
        #1;
        chk("rw3_ce_in_read", 32'(ce3), 32'd0);
        ack_before = ack3_cnt;
        rst3 = 1'b1;
        @(posedge CLK);
        #1;
        chk_reset3("midread_rst");
        req3 = 1'b0;
        rst3 = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("midread_no_ack", 32'(ack3_cnt - ack_before), 32'd0);
        do_read3(16'o002000, 16'o012345);

        repeat (4) @(posedge CLK);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("strobe_rule_viol", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
